// File: rtl/wb_queue.sv
// Write-back queue: buffers EX/MEM results and retires one register-file write per cycle.
// Ports: clk/rst; in_valid/in_ready/in_reg/in_data; drain_en; RegWrite/w_reg/w_data;
//   count; rd_reg1/rd_reg2 -> hit1/hit2, fwd_data1/fwd_data2 (WB_QUEUE_FORWARD_EN).
module wb_queue #(
  parameter int WORD  = 64,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_reg,
  input  logic [WORD-1:0] in_data,
  input  logic            drain_en,
  output logic            RegWrite,
  output logic [4:0]      w_reg,
  output logic [WORD-1:0] w_data,
  output logic [AW:0]     count,
  input  logic [4:0]      rd_reg1,
  input  logic [4:0]      rd_reg2,
  output logic            hit1,
  output logic            hit2,
  output logic [WORD-1:0] fwd_data1,
  output logic [WORD-1:0] fwd_data2
);

  logic [4:0]      mem_reg  [DEPTH];
  logic [WORD-1:0] mem_data [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  // Full blocks input even when a pop happens on the same edge.
  assign in_ready = (count != (AW+1)'(DEPTH));
  // XZR results complete the handshake but are dropped.
  assign push = in_valid && in_ready && (in_reg != 5'd31);
  // Uses pre-edge count, so a fresh push is never popped the same edge.
  assign pop  = drain_en && (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr]  <= in_reg;
      mem_data[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      RegWrite <= 1'b0;
      w_reg    <= '0;
      w_data   <= '0;
    end else begin
      RegWrite <= pop;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        w_reg  <= mem_reg[rd_ptr];
        w_data <= mem_data[rd_ptr];
      end
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef WB_QUEUE_FORWARD_EN
  // Scan oldest to newest so later matches override earlier ones;
  // the output stage is older than any queued entry.
  function automatic logic [WORD:0] lookup(
    input logic [4:0]      rd,
    input logic            ow,
    input logic [4:0]      oreg,
    input logic [WORD-1:0] odata,
    input logic [AW-1:0]   head,
    input logic [AW:0]     occ
  );
    logic            h;
    logic [WORD-1:0] v;
    logic [AW-1:0]   idx;
    h = 1'b0;
    v = '0;
    if (rd != 5'd31) begin
      if (ow && oreg == rd) begin
        h = 1'b1;
        v = odata;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + AW'(i);
        if ((AW+1)'(i) < occ && mem_reg[idx] == rd) begin
          h = 1'b1;
          v = mem_data[idx];
        end
      end
    end
    return {h, v};
  endfunction

  always_comb begin
    {hit1, fwd_data1} = lookup(rd_reg1, RegWrite, w_reg,
                               w_data, rd_ptr, count);
    {hit2, fwd_data2} = lookup(rd_reg2, RegWrite, w_reg,
                               w_data, rd_ptr, count);
  end
`else
  logic unused_rd;
  assign unused_rd = ^{rd_reg1, rd_reg2};
  assign hit1      = 1'b0;
  assign hit2      = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Testbench for wb_queue: vector table, directed corner cases,
// and randomized traffic against a queue-based reference model.
module tb_wb_queue;

  localparam int WORD  = 64;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic            tb_clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [4:0]      in_reg = '0;
  logic [WORD-1:0] in_data = '0;
  logic            drain_en = 1'b0;
  logic            RegWrite;
  logic [4:0]      w_reg;
  logic [WORD-1:0] w_data;
  logic [AW:0]     count;
  logic [4:0]      rd_reg1 = '0;
  logic [4:0]      rd_reg2 = '0;
  logic            hit1;
  logic            hit2;
  logic [WORD-1:0] fwd_data1;
  logic [WORD-1:0] fwd_data2;

  int errors = 0;
  int checks = 0;

  always #5 tb_clk = ~tb_clk;

  wb_queue #(.WORD(WORD), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(tb_clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg(in_reg), .in_data(in_data),
    .drain_en(drain_en),
    .RegWrite(RegWrite), .w_reg(w_reg), .w_data(w_data),
    .count(count),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
    .hit1(hit1), .hit2(hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  // Reference model: a plain queue of pending writes plus the output stage.
  typedef struct {
    logic [4:0]      r;
    logic [WORD-1:0] d;
  } ent_t;

  ent_t            q[$];
  logic            m_rw = 1'b0;
  logic [4:0]      m_wreg = '0;
  logic [WORD-1:0] m_wdata = '0;

  task automatic chk(input string name, input logic [WORD-1:0] act,
                     input logic [WORD-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WORD:0] m_fwd(input logic [4:0] rd);
    logic [WORD:0] res;
    res = '0;
`ifdef WB_QUEUE_FORWARD_EN
    if (rd != 5'd31) begin
      if (m_rw && m_wreg == rd)
        res = {1'b1, m_wdata};
      foreach (q[i])
        if (q[i].r == rd)
          res = {1'b1, q[i].d};
    end
`endif
    return res;
  endfunction

  task automatic model_edge(input logic r, input logic v,
                            input logic [4:0] ir,
                            input logic [WORD-1:0] id,
                            input logic dr);
    ent_t e;
    bit   rdy;
    if (r) begin
      q.delete();
      m_rw = 1'b0;
      m_wreg = '0;
      m_wdata = '0;
    end else begin
      rdy = (q.size() != DEPTH);
      m_rw = 1'b0;
      if (dr && q.size() != 0) begin
        e = q.pop_front();
        m_rw = 1'b1;
        m_wreg = e.r;
        m_wdata = e.d;
      end
      if (v && rdy && ir != 5'd31) begin
        e.r = ir;
        e.d = id;
        q.push_back(e);
      end
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs,
  // cross the edge, then check registered outputs.
  task automatic step(input logic r, input logic v,
                      input logic [4:0] ir,
                      input logic [WORD-1:0] id,
                      input logic dr,
                      input logic [4:0] r1, input logic [4:0] r2,
                      output logic rdy_pre);
    logic [WORD:0] f1;
    logic [WORD:0] f2;
    rst = r;
    in_valid = v;
    in_reg = ir;
    in_data = id;
    drain_en = dr;
    rd_reg1 = r1;
    rd_reg2 = r2;
    #1;
    rdy_pre = in_ready;
    f1 = m_fwd(r1);
    f2 = m_fwd(r2);
    chk("m_in_ready", {63'd0, in_ready}, {63'd0, q.size() != DEPTH});
    chk("m_hit1", {63'd0, hit1}, {63'd0, f1[WORD]});
    chk("m_fwd1", fwd_data1, f1[WORD-1:0]);
    chk("m_hit2", {63'd0, hit2}, {63'd0, f2[WORD]});
    chk("m_fwd2", fwd_data2, f2[WORD-1:0]);
    @(posedge tb_clk);
    model_edge(r, v, ir, id, dr);
    @(negedge tb_clk);
    chk("m_regwrite", {63'd0, RegWrite}, {63'd0, m_rw});
    chk("m_w_reg", {59'd0, w_reg}, {59'd0, m_wreg});
    chk("m_w_data", w_data, m_wdata);
    chk("m_count", {61'd0, count}, 64'(q.size()));
  endtask

  typedef struct {
    logic            v;
    logic [4:0]      ir;
    logic [WORD-1:0] id;
    logic            dr;
    logic            e_rdy;
    logic            e_rw;
    logic [4:0]      e_wreg;
    logic [WORD-1:0] e_wdata;
    logic [AW:0]     e_cnt;
  } vec_t;

  vec_t vt[16];
  logic rdy;

  initial begin
    // v  reg  data   dr   rdy rw  wreg wdata cnt
    vt[0]  = '{1, 9,  1,      1, 1, 0, 0,  0,  1};
    vt[1]  = '{0, 0,  0,      1, 1, 1, 9,  1,  0};
    vt[2]  = '{0, 0,  0,      1, 1, 0, 9,  1,  0};
    vt[3]  = '{1, 10, 20,     0, 1, 0, 9,  1,  1};
    vt[4]  = '{1, 11, 0,      0, 1, 0, 9,  1,  2};
    vt[5]  = '{1, 12, 5,      0, 1, 0, 9,  1,  3};
    vt[6]  = '{1, 13, 7,      0, 1, 0, 9,  1,  4};
    vt[7]  = '{1, 14, 99,     0, 0, 0, 9,  1,  4};
    vt[8]  = '{1, 14, 99,     1, 0, 1, 10, 20, 3};
    vt[9]  = '{1, 14, 99,     1, 1, 1, 11, 0,  3};
    vt[10] = '{0, 0,  0,      1, 1, 1, 12, 5,  2};
    vt[11] = '{0, 0,  0,      1, 1, 1, 13, 7,  1};
    vt[12] = '{0, 0,  0,      1, 1, 1, 14, 99, 0};
    vt[13] = '{0, 0,  0,      1, 1, 0, 14, 99, 0};
    vt[14] = '{1, 31, 'hFFFF, 1, 1, 0, 14, 99, 0};
    vt[15] = '{0, 0,  0,      1, 1, 0, 14, 99, 0};

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge tb_clk);
    model_edge(1, 0, 0, 0, 0);
    @(negedge tb_clk);
    rst = 1'b0;
    #1;
    chk("rst_regwrite", {63'd0, RegWrite}, 64'd0);
    chk("rst_w_reg", {59'd0, w_reg}, 64'd0);
    chk("rst_w_data", w_data, 64'd0);
    chk("rst_count", {61'd0, count}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Vector table: single push, fill/hold/drain, XZR drop
    for (int i = 0; i < 16; i++) begin
      step(0, vt[i].v, vt[i].ir, vt[i].id, vt[i].dr, 0, 0, rdy);
      chk($sformatf("vec%0d_ready", i), {63'd0, rdy}, {63'd0, vt[i].e_rdy});
      chk($sformatf("vec%0d_rw", i), {63'd0, RegWrite}, {63'd0, vt[i].e_rw});
      chk($sformatf("vec%0d_wreg", i), {59'd0, w_reg}, {59'd0, vt[i].e_wreg});
      chk($sformatf("vec%0d_wdata", i), w_data, vt[i].e_wdata);
      chk($sformatf("vec%0d_cnt", i), {61'd0, count}, {61'd0, vt[i].e_cnt});
    end

    // Reset with entries queued and a write pending
    for (int i = 0; i < 4; i++)
      step(0, 1, 5'(20 + i), 64'(100 + i), 0, 0, 0, rdy);
    step(0, 0, 0, 0, 1, 0, 0, rdy);
    chk("pend_rw", {63'd0, RegWrite}, 64'd1);
    chk("pend_cnt", {61'd0, count}, 64'd3);
    step(1, 0, 0, 0, 1, 0, 0, rdy);
    chk("rst5_rw", {63'd0, RegWrite}, 64'd0);
    chk("rst5_cnt", {61'd0, count}, 64'd0);
    chk("rst5_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 0, 0, rdy);
      chk("rst5_no_write", {63'd0, RegWrite}, 64'd0);
    end

    // Forwarding: newest queued entry wins
    step(0, 1, 9, 1, 0, 0, 0, rdy);
    step(0, 1, 9, 30, 0, 0, 0, rdy);
    rst = 1'b0;
    in_valid = 1'b0;
    rd_reg1 = 5'd9;
    rd_reg2 = 5'd22;
    #1;
`ifdef WB_QUEUE_FORWARD_EN
    chk("fwd_hit1", {63'd0, hit1}, 64'd1);
    chk("fwd_data1", fwd_data1, 64'd30);
`else
    chk("fwd_hit1", {63'd0, hit1}, 64'd0);
    chk("fwd_data1", fwd_data1, 64'd0);
`endif
    chk("fwd_hit2", {63'd0, hit2}, 64'd0);
    chk("fwd_data2", fwd_data2, 64'd0);
    @(negedge tb_clk);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] ir;
      logic [4:0] r1;
      logic [4:0] r2;
      ir = 5'($urandom_range(0, 8));
      r1 = 5'($urandom_range(0, 8));
      r2 = 5'($urandom_range(0, 8));
      if (ir == 5'd8) ir = 5'd31;
      if (r1 == 5'd8) r1 = 5'd31;
      if (r2 == 5'd8) r2 = 5'd31;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, ir,
           {$urandom, $urandom}, $urandom_range(0, 9) < 5, r1, r2, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-back buffer on the producer side of the register-file write port. ID only reads that file; this block generates its RegWrite / w_reg / w_data.
- Accepts completed results (destination register + 64-bit value) from EX/MEM over a valid/ready handshake.
- Buffers results in a small in-order FIFO and retires at most one register-file write per cycle.
- Optionally answers ID read-port lookups, so ID can bypass values still queued.

Parameters:
- WORD, 64, data width in bits.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 2, pointer width; log2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a result.
- in_ready  output  1  block can accept a result this cycle.
- in_reg  input  5  destination register index.
- in_data  input  WORD  result value.
- drain_en  input  1  register file may accept a write; 0 stalls retirement.
- RegWrite  output  1  register-file write strobe.
- w_reg  output  5  register to be written.
- w_data  output  WORD  data to be written.
- count  output  AW+1  FIFO occupancy (0..DEPTH); excludes the output stage.
- rd_reg1  input  5  ID read register 1 (forwarding lookup).
- rd_reg2  input  5  ID read register 2 (forwarding lookup).
- hit1  output  1  forwarding match for rd_reg1.
- hit2  output  1  forwarding match for rd_reg2.
- fwd_data1  output  WORD  forwarded value for rd_reg1.
- fwd_data2  output  WORD  forwarded value for rd_reg2.

Behaviour:
- Reset (rst=1 at an edge):
  - count=0; read/write pointers=0.
  - RegWrite=0, w_reg=0, w_data=0.
  - FIFO contents are don't-care.
  - Reset mid-operation discards every queued result and any in-flight output write; the output write is not issued on the following cycle.
- in_ready = (count != DEPTH); purely combinational from count.
- Push: in_valid && in_ready at an edge.
  - in_reg == 31 (XZR): handshake completes but nothing is enqueued and count is unchanged.
  - Otherwise {in_reg, in_data} is written at the write pointer.
  - Write pointer increments and wraps modulo DEPTH.
- Pop: drain_en && count != 0 at an edge.
  - Head entry is loaded into the output registers and RegWrite=1 for the next cycle.
  - Read pointer wraps modulo DEPTH.
- If no pop occurs at an edge, RegWrite=0 next cycle; w_reg and w_data hold their last values.
- RegWrite is a one-cycle pulse per retired entry. Back-to-back pops give continuous RegWrite=1 with new w_reg/w_data each cycle.
- Simultaneous push and pop: count unchanged; both pointers advance.
  - When full, in_ready=0 even if a pop occurs in the same cycle (no full-state pass-through).
  - When empty, a push is not popped in the same edge (no bypass).
- Latency: a result accepted at edge T, with drain_en high, drives RegWrite during the cycle after edge T+1. Minimum latency is 2 cycles.
- Ordering: strictly FIFO. Writes to the same register retire in acceptance order.
- drain_en=0: no pops; the FIFO fills until in_ready drops; no overflow is possible.
- Occupancy: count tracks pushes minus pops. The output stage is a separate register outside count.

Optional Feature:
- Macro: WB_QUEUE_FORWARD_EN.
- Defined:
  - hitN/fwd_dataN are combinational lookups of rd_regN.
  - Search space: all valid FIFO entries plus the output stage when RegWrite=1.
  - Newest matching entry wins; FIFO newest-to-oldest ranks ahead of the output stage.
  - rd_regN == 31 never hits.
  - No hit gives hitN=0, fwd_dataN=0.
- Not defined: hit1/hit2 tied 0, fwd_data1/fwd_data2 tied 0, and no search logic is synthesised.

Test Plan:
1. Reset, then push {reg 9, data 1} with drain_en=1 → the cycle after the next edge shows RegWrite=1, w_reg=9, w_data=1 for exactly one cycle; count returns to 0.
2. drain_en=0, push regs 10,11,12,13 with data 20,0,5,7 → count=4 and in_ready=0; a 5th push is held. Then drain_en=1 → four consecutive RegWrite pulses in order 10,11,12,13, and the held 5th result is accepted once count<4.
3. Push in_reg=31, data 0xFFFF → handshake completes, count stays 0, RegWrite never asserts.
4. Full FIFO with simultaneous pop and in_valid=1 → in_ready=0 and the push is not taken. Next cycle count=3 and the push is accepted.
5. Assert rst with 3 entries queued and RegWrite pending → next cycle RegWrite=0, count=0, in_ready=1; no queued write ever appears.
6. (WB_QUEUE_FORWARD_EN) drain_en=0, queue {9,1} then {9,30}; rd_reg1=9, rd_reg2=22 → hit1=1, fwd_data1=30, hit2=0, fwd_data2=0. Without the macro: hit1=0, fwd_data1=0.
